// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the multi-cycle data-memory stage.
//   state_t   : controller states (IDLE, WAIT, HALT)
//   op_t      : latched operation encoding (OP_RD, OP_WR)
//   clog2     : ceiling log2, used to size the latency counter
//   cnt_width : latency counter width, never narrower than one bit
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // LATENCY=1 never loads a nonzero count, but a zero-width vector is
  // not legal, so keep at least one bit.
  function automatic int cnt_width(input int latency);
    return (clog2(latency) < 1) ? 1 : clog2(latency);
  endfunction

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, word organised, no reset on contents.
// A read presents data on o_dout the cycle after i_en; o_dout holds its
// value between reads (writes do not disturb it).
//
// Ports:
//   i_clk   clock
//   i_en    access enable
//   i_wr    1 = write i_din to word i_idx, 0 = read word i_idx
//   i_idx   word index
//   i_din   write data
//   o_dout  read data (registered)
// ---------------------------------------------------------------------------
module mem_array
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_wr,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DATA_W-1:0]     i_din,
  output logic [DATA_W-1:0]     o_dout
);

  logic [DATA_W-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_wr) begin
        r_mem[i_idx] <= i_din;
      end else begin
        r_dout <= r_mem[i_idx];
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/mem_stage_stall.sv
// ---------------------------------------------------------------------------
// mem_stage_stall
// Multi-cycle data-memory stage. Accepts one load or store at a time,
// runs it against an internal word-organised single-port array with a
// configurable access latency, and holds the pipeline with o_stall until
// the access completes. Odd addresses and read+write together are
// rejected with an error pulse. A dump request halts the block (sticky)
// once any access in flight has completed.
//
// Timing: a request accepted in cycle 0 produces o_done in cycle LATENCY.
// The accept cycle counts as the first latency cycle, so the array access
// is issued on the edge closing cycle LATENCY-1.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous, active-high reset
//   i_addr       byte address (word index = i_addr[DEPTH_LOG2:1])
//   i_wdata      store data
//   i_mem_read   load request
//   i_mem_write  store request
//   i_dump       halt request, honoured after the current access
//   o_rdata      load data, valid from the done cycle of a load
//   o_stall      pipeline hold (combinational)
//   o_done       one-cycle completion pulse
//   o_err        one-cycle illegal-request pulse (coincides with o_done)
//   o_halted     sticky halt flag
// ---------------------------------------------------------------------------
module mem_stage_stall
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_dump,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_err,
  output logic              o_halted
);

  localparam int                CNT_W  = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  // FSM state and datapath latches
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_dump_pend;
  logic                  w_dump_pend_nxt;
  op_t                   r_op;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic                  w_latch;

  // Output registers
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  r_ld_done;
  logic                  w_ld_nxt;
  logic [DATA_W-1:0]     r_rdata;

  // Array interface
  logic                  w_ram_en;
  logic                  w_ram_wr;
  logic [DEPTH_LOG2-1:0] w_ram_idx;
  logic [DATA_W-1:0]     w_ram_din;
  logic [DATA_W-1:0]     w_ram_dout;

  // Request decode
  logic                  w_halted;
  logic                  w_req;
  logic                  w_illegal;
  logic                  w_accept;
  logic [DEPTH_LOG2-1:0] w_in_idx;
  logic                  w_unused_addr;

  assign w_halted  = (r_state == HALT);
  assign w_req     = (i_mem_read | i_mem_write) & ~w_halted;
  assign w_illegal = i_addr[0] | (i_mem_read & i_mem_write);
  // The done cycle still sees the held request; blocking on r_done stops
  // it from being accepted a second time.
  assign w_accept  = (r_state == IDLE) & w_req & ~r_done;
  assign w_in_idx  = i_addr[DEPTH_LOG2:1];

  // Bits above the word index alias and are deliberately ignored.
  assign w_unused_addr = ^i_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_dump_pend_nxt = r_dump_pend;
    w_latch         = 1'b0;
    w_ram_en        = 1'b0;
    w_ram_wr        = 1'b0;
    w_ram_idx       = r_idx;
    w_ram_din       = r_wdata;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_ld_nxt        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = i_dump ? HALT : IDLE;
          end else if (LATENCY == 1) begin
            // Single-cycle latency: the accept edge is also the access
            // edge, driven straight from the (stable) request inputs.
            w_ram_en    = 1'b1;
            w_ram_wr    = i_mem_write;
            w_ram_idx   = w_in_idx;
            w_ram_din   = i_wdata;
            w_done_nxt  = 1'b1;
            w_ld_nxt    = i_mem_read;
            w_state_nxt = i_dump ? HALT : IDLE;
          end else begin
            w_latch         = 1'b1;
            w_cnt_nxt       = LAT_M1;
            w_dump_pend_nxt = i_dump;
            w_state_nxt     = WAIT;
          end
        end else if (i_dump) begin
          w_state_nxt = HALT;
        end
      end

      WAIT: begin
        w_dump_pend_nxt = r_dump_pend | i_dump;
        if (r_cnt > CNT_1) begin
          w_cnt_nxt = r_cnt - CNT_1;
        end else begin
          w_cnt_nxt       = '0;
          w_ram_en        = 1'b1;
          w_ram_wr        = (r_op == OP_WR);
          w_done_nxt      = 1'b1;
          w_ld_nxt        = (r_op == OP_RD);
          w_dump_pend_nxt = 1'b0;
          w_state_nxt     = (r_dump_pend | i_dump) ? HALT : IDLE;
        end
      end

      HALT: begin
        w_state_nxt = HALT;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_dump_pend <= 1'b0;
      r_op        <= OP_RD;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ld_done   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_dump_pend <= w_dump_pend_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_ld_done   <= w_ld_nxt;
      if (w_latch) begin
        r_op    <= i_mem_write ? OP_WR : OP_RD;
        r_idx   <= w_in_idx;
        r_wdata <= i_wdata;
      end
      // Freeze the load result so later stores/reads cannot disturb it.
      if (r_ld_done) begin
        r_rdata <= w_ram_dout;
      end
    end
  end

  // Reset can land on the access edge; gating the enable keeps a pending
  // store out of the array.
  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .i_clk  (i_clk),
    .i_en   (w_ram_en & ~i_rst),
    .i_wr   (w_ram_wr),
    .i_idx  (w_ram_idx),
    .i_din  (w_ram_din),
    .o_dout (w_ram_dout)
  );

  // In the done cycle of a load the array output is already the answer;
  // afterwards the frozen copy is presented.
  assign o_rdata  = r_ld_done ? w_ram_dout : r_rdata;
  assign o_stall  = w_req & ~r_done;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_halted = w_halted;

endmodule

// File: tb/tb_mem_stage_stall.sv
module tb_mem_stage_stall;

  logic        clk;
  logic        rst   [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        mrd   [3];
  logic        mwr   [3];
  logic        dump  [3];
  logic [15:0] rdata [3];
  logic        stall [3];
  logic        done  [3];
  logic        err   [3];
  logic        halted[3];

  int n_checks = 0;
  int n_errors = 0;

  // instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_stall #(
      .DATA_W     (16),
      .ADDR_W     (16),
      .DEPTH_LOG2 (4),
      .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst[g]),
      .i_addr      (addr[g]),
      .i_wdata     (wdata[g]),
      .i_mem_read  (mrd[g]),
      .i_mem_write (mwr[g]),
      .i_dump      (dump[g]),
      .o_rdata     (rdata[g]),
      .o_stall     (stall[g]),
      .o_done      (done[g]),
      .o_err       (err[g]),
      .o_halted    (halted[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and hold it until done (bounded). Checks the done
  // cycle, the number of stall cycles, stall in the done cycle, err and
  // optionally rdata. dump_cyc selects the cycle in which dump is pulsed.
  task automatic run_op(input int k, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input int dump_cyc, input int exp_cyc, input logic exp_err,
                        input logic chk_rd, input logic [15:0] exp_rd, input string tag);
    int c;
    int stalls;
    bit got;
    @(posedge clk); #1;
    addr[k] = a; wdata[k] = d; mrd[k] = rd; mwr[k] = wr;
    c = 0; stalls = 0; got = 0;
    while (!got && c <= 20) begin
      dump[k] = (c == dump_cyc);
      @(negedge clk);
      if (done[k]) begin
        got = 1;
      end else begin
        if (stall[k]) stalls++;
        @(posedge clk); #1;
        c++;
      end
    end
    check_eq({tag, "/done_cyc"}, c, exp_cyc);
    check_eq({tag, "/stalls"}, stalls, exp_cyc);
    check_eq({tag, "/stall_at_done"}, {31'd0, stall[k]}, 0);
    check_eq({tag, "/err"}, {31'd0, err[k]}, {31'd0, exp_err});
    if (chk_rd) check_eq({tag, "/rdata"}, {16'd0, rdata[k]}, {16'd0, exp_rd});
    @(posedge clk); #1;
    mrd[k] = 0; mwr[k] = 0; dump[k] = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1; addr[i] = 0; wdata[i] = 0; mrd[i] = 0; mwr[i] = 0; dump[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 0;
    @(negedge clk);
    check_eq("rst/rdata",  {16'd0, rdata[0]}, 0);
    check_eq("rst/done",   {31'd0, done[0]}, 0);
    check_eq("rst/err",    {31'd0, err[0]}, 0);
    check_eq("rst/halted", {31'd0, halted[0]}, 0);
    check_eq("rst/stall",  {31'd0, stall[0]}, 0);

    // LATENCY=2: store then load
    run_op(0, 0, 1, 16'h0010, 16'hBEEF, -1, 2, 0, 0, 16'h0, "st_beef");
    run_op(0, 1, 0, 16'h0010, 16'h0000, -1, 2, 0, 1, 16'hBEEF, "ld_beef");
    @(negedge clk);
    check_eq("ld_beef/hold", {16'd0, rdata[0]}, 16'hBEEF);

    // aliasing across 16 words
    run_op(0, 0, 1, 16'h0002, 16'h1234, -1, 2, 0, 0, 16'h0, "st_1234");
    run_op(0, 1, 0, 16'h0022, 16'h0000, -1, 2, 0, 1, 16'h1234, "ld_alias");

    // illegal requests
    run_op(0, 1, 0, 16'h0011, 16'h0000, -1, 1, 1, 1, 16'h1234, "ld_unal");
    run_op(0, 0, 1, 16'h0011, 16'hDEAD, -1, 1, 1, 1, 16'h1234, "st_unal");
    run_op(0, 1, 1, 16'h0010, 16'hDEAD, -1, 1, 1, 1, 16'h1234, "rd_wr");
    run_op(0, 1, 0, 16'h0010, 16'h0000, -1, 2, 0, 1, 16'hBEEF, "ld_intact");

    // reset in cycle 1 of a store
    run_op(0, 0, 1, 16'h0004, 16'hAAAA, -1, 2, 0, 0, 16'h0, "st_aaaa");
    run_op(0, 1, 0, 16'h0010, 16'h0000, -1, 2, 0, 1, 16'hBEEF, "ld_pre_rst");
    @(posedge clk); #1;
    addr[0] = 16'h0004; wdata[0] = 16'h5555; mwr[0] = 1;
    @(posedge clk); #1;
    rst[0] = 1;
    @(posedge clk); #1;
    rst[0] = 0; mwr[0] = 0;
    @(negedge clk);
    check_eq("midrst/rdata",  {16'd0, rdata[0]}, 0);
    check_eq("midrst/done",   {31'd0, done[0]}, 0);
    check_eq("midrst/err",    {31'd0, err[0]}, 0);
    check_eq("midrst/halted", {31'd0, halted[0]}, 0);
    check_eq("midrst/stall",  {31'd0, stall[0]}, 0);
    run_op(0, 1, 0, 16'h0004, 16'h0000, -1, 2, 0, 1, 16'hAAAA, "ld_old");

    // LATENCY=1: preload then four back-to-back loads
    for (int i = 0; i < 4; i++) begin
      run_op(1, 0, 1, 16'(2 * i), 16'(16'h1111 * (i + 1)), -1, 1, 0, 0, 16'h0, "l1_st");
    end
    @(posedge clk); #1;
    addr[1] = 16'h0000; mrd[1] = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("l1_acc/stall", {31'd0, stall[1]}, 1);
      check_eq("l1_acc/done",  {31'd0, done[1]}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("l1_done/stall", {31'd0, stall[1]}, 0);
      check_eq("l1_done/done",  {31'd0, done[1]}, 1);
      check_eq("l1_done/rdata", {16'd0, rdata[1]}, {16'd0, 16'(16'h1111 * (i + 1))});
      @(posedge clk); #1;
      addr[1] = 16'(2 * (i + 1));
    end
    mrd[1] = 0;
    // dump with no request halts directly
    dump[1] = 1;
    @(posedge clk); #1;
    dump[1] = 0;
    @(negedge clk);
    check_eq("l1_idle_dump/halted", {31'd0, halted[1]}, 1);

    // LATENCY=3: dump during a store
    run_op(2, 0, 1, 16'h0006, 16'h7777, 1, 3, 0, 0, 16'h0, "l3_dump");
    @(negedge clk);
    check_eq("l3_dump/halted", {31'd0, halted[2]}, 1);
    @(posedge clk); #1;
    addr[2] = 16'h0006; mrd[2] = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("halt_rd/stall", {31'd0, stall[2]}, 0);
      check_eq("halt_rd/done",  {31'd0, done[2]}, 0);
      @(posedge clk); #1;
    end
    mrd[2] = 0;
    rst[2] = 1;
    @(posedge clk); #1;
    rst[2] = 0;
    @(negedge clk);
    check_eq("l3_rst/halted", {31'd0, halted[2]}, 0);
    run_op(2, 1, 0, 16'h0006, 16'h0000, -1, 3, 0, 1, 16'h7777, "l3_ld");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_stall.md
Name: mem_stage_stall

Overview:
Parametrised, multi-cycle data-memory stage for the WISC processor pipeline. It replaces the single-cycle memory stage. The block accepts one load or store at a time and runs it against an internal word-organised single-port array with a configurable access latency. It holds the pipeline with a stall output until the access completes. It also adds alignment checking and a sticky halt on dump.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, byte-address width in bits
DEPTH_LOG2, 10, log2 of array depth in words (must satisfy DEPTH_LOG2 <= ADDR_W-1)
LATENCY, 2, cycles from request acceptance to done (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
addr  in  ADDR_W  byte address, from the ALU result
wdata  in  DATA_W  store data
mem_read  in  1  load request
mem_write  in  1  store request
dump  in  1  halt request; stops the block after the current access
rdata  out  DATA_W  load data, registered
stall  out  1  pipeline hold, combinational
done  out  1  one-cycle completion pulse, registered
err  out  1  one-cycle pulse for an illegal request, registered
halted  out  1  sticky halt flag

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rdata=0, done=0, err=0, halted=0, state=IDLE, counter=0. Array contents are not cleared.
- Reset mid-access: the state returns to IDLE. A pending store is discarded and the array is not written.
- Address mapping: word index = addr[DEPTH_LOG2:1]. Upper address bits are ignored, so addresses alias and wrap at 2^DEPTH_LOG2 words.
- Request: req = (mem_read | mem_write) & ~halted.
- Illegal request: addr[0]=1, or mem_read and mem_write both high. It is accepted from IDLE, but no array access occurs. err and done pulse together on the next cycle, and rdata holds its value.
- FSM states: IDLE, WAIT, HALT.
- IDLE, legal req: latch op, word index and wdata; load counter with LATENCY-1; go to WAIT.
- WAIT: while the counter is nonzero, decrement it. At zero, perform the access: a load captures array[idx] into rdata, a store writes array[idx]=wdata. Registered done is high in the following cycle. Go to IDLE, or to HALT if a dump is pending.
- Timing: acceptance is in cycle 0, and done is high in cycle LATENCY.
- stall = req & ~done, combinational. The requester holds addr, wdata and its read/write controls stable while stall=1.
- In the done cycle stall=0 and the pipeline advances. The next request is accepted in the following cycle, so there are no back-to-back accepts.
- rdata changes only on a completed legal load. It holds its value across stores, errors and idle cycles.
- dump in IDLE with no req: go to HALT next cycle.
- dump with req in IDLE, or during WAIT: latch dump_pending. The current access completes normally, then the FSM enters HALT.
- HALT: halted=1 sticky. All requests are ignored (req=0, so stall=0), and no done or err is produced. Only rst leaves HALT.
- Simultaneous dump and a new req in IDLE: the request is serviced first, then HALT.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE, WAIT, HALT), op encoding (OP_RD, OP_WR), and a latency-counter width function clog2(LATENCY).
- Sub-module mem_array: single-port synchronous RAM. Parameters DATA_W and DEPTH_LOG2. Ports clk, en, wr, idx, din, dout; read data is valid the cycle after en.
- The top level holds the FSM, the counter, the latches and the alignment check.

Test Plan:
- Store then load, LATENCY=2. Store 0xBEEF to addr 0x0010, then load from 0x0010 -> stall high 2 cycles per access; done in cycle 2 of each access; rdata=0xBEEF after the load's done.
- Aliasing, DEPTH_LOG2=4. Store 0x1234 to addr 0x0002, load from 0x0022 -> rdata=0x1234.
- Unaligned load from addr 0x0011 -> err=1 and done=1 in the next cycle; stall=1 for exactly 1 cycle; rdata unchanged; array unchanged.
- LATENCY=1 sweep. Four consecutive loads -> each gets one stall cycle followed by done; an idle gap of 1 cycle between accepts.
- Dump asserted in cycle 1 of a store, LATENCY=3 -> the store completes (done in cycle 3), then halted=1; a later mem_read gives stall=0 and done=0.
- rst asserted in cycle 1 of a store to 0x0004 -> all outputs return to 0; a later load of 0x0004 returns the old contents, not wdata.
